elevator_request_queue: RTL and testbench

- Registered, parametrised request queue for the elevator controller.
- Holds up to DEPTH distinct floor requests in arrival order and deduplicates new button presses.
- When the car reports its position, removes the request for the current floor and flags a stop.
- Sits between the button-press synchroniser and the car motion FSM. Replaces the fixed 4-entry, 2-bit combinational queue with a clocked, generalised version that reports overflow.

---
 rtl/elevator_request_queue.sv | 150 +++++++++++++++
 tb/tb_elevator_request_queue.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/elevator_request_queue.sv
// Clocked, deduplicating floor-request queue with same-cycle service and overflow reporting.
// Optional saturating drop counter on port drop_cnt when QUEUE_DROP_CNT_EN is defined.
module elevator_request_queue #(
  parameter int LVL_W = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pressed_en,
  input  logic [LVL_W-1:0]       pressed_lvl,
  input  logic                   pos_en,
  input  logic [LVL_W-1:0]       pos_lvl,
  output logic [DEPTH*LVL_W-1:0] queue,
  output logic [CNT_W-1:0]       tail,
  output logic                   head_valid,
  output logic [LVL_W-1:0]       head_lvl,
  output logic                   full,
  output logic                   stop_at_pos_lvl,
`ifdef QUEUE_DROP_CNT_EN
  output logic [7:0]             drop_cnt,
`endif
  output logic                   drop
);

  logic [LVL_W-1:0] r_q [DEPTH];
  logic [CNT_W-1:0] r_tail;
  logic             r_stop;
  logic             r_drop;

  logic [LVL_W-1:0] w_q_rm [DEPTH];
  logic [LVL_W-1:0] w_q_nx [DEPTH];
  logic [CNT_W-1:0] w_cnt_rm;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_seen;
  logic             w_dup;
  logic             w_hit;
  logic             w_drop_n;

  // Next-state: remove the entry at pos_lvl (closing the gap), then try to append the press.
  always_comb begin
    w_q_rm   = r_q;
    w_seen   = 1'b0;
    w_dup    = 1'b0;
    w_hit    = 1'b0;
    w_drop_n = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (pos_en && (CNT_W'(i) < r_tail) && (r_q[i] == pos_lvl)) begin
        w_seen = 1'b1;
      end else begin
        w_seen = w_seen;
      end
      if (w_seen) begin
        w_q_rm[i] = r_q[i+1];
      end else begin
        w_q_rm[i] = r_q[i];
      end
    end
    // The last slot is either the match itself or vacated by the shift.
    if (pos_en && (CNT_W'(DEPTH - 1) < r_tail) && (r_q[DEPTH-1] == pos_lvl)) begin
      w_seen = 1'b1;
    end else begin
      w_seen = w_seen;
    end
    if (w_seen) begin
      w_q_rm[DEPTH-1] = '0;
    end else begin
      w_q_rm[DEPTH-1] = r_q[DEPTH-1];
    end
    w_cnt_rm = w_seen ? (r_tail - CNT_W'(1)) : r_tail;
    w_hit    = w_seen;

    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < w_cnt_rm) && (w_q_rm[i] == pressed_lvl)) begin
        w_dup = 1'b1;
      end else begin
        w_dup = w_dup;
      end
    end

    w_q_nx   = w_q_rm;
    w_cnt_nx = w_cnt_rm;
    if (pressed_en) begin
      if (pos_en && (pressed_lvl == pos_lvl)) begin
        w_hit = 1'b1;
      end else if (w_dup) begin
        w_hit = w_hit;
      end else if (w_cnt_rm < CNT_W'(DEPTH)) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == w_cnt_rm) begin
            w_q_nx[i] = pressed_lvl;
          end else begin
            w_q_nx[i] = w_q_rm[i];
          end
        end
        w_cnt_nx = w_cnt_rm + CNT_W'(1);
      end else begin
        w_drop_n = 1'b1;
      end
    end else begin
      w_drop_n = 1'b0;
    end
  end

  // State and pulse registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= '0;
      end
      r_tail <= '0;
      r_stop <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      r_q    <= w_q_nx;
      r_tail <= w_cnt_nx;
      r_stop <= w_hit;
      r_drop <= w_drop_n;
    end
  end

`ifdef QUEUE_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  // Saturating count of drop pulses, stepped on the edge that registers drop high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop_n && (r_drop_cnt != 8'd255)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end else begin
      r_drop_cnt <= r_drop_cnt;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign queue[g*LVL_W +: LVL_W] = r_q[g];
  end

  assign tail            = r_tail;
  assign head_valid      = (r_tail != CNT_W'(0));
  assign head_lvl        = r_q[0];
  assign full            = (r_tail == CNT_W'(DEPTH));
  assign stop_at_pos_lvl = r_stop;
  assign drop            = r_drop;

endmodule

// File: tb/tb_elevator_request_queue.sv
// Directed self-checking bench: a DEPTH=4 and a DEPTH=3 queue share one stimulus stream.
module tb_elevator_request_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pressed_en;
  logic [1:0] pressed_lvl;
  logic       pos_en;
  logic [1:0] pos_lvl;

  logic [7:0] q4;
  logic [2:0] tail4;
  logic       hv4, full4, stop4, drop4;
  logic [1:0] head4;
  logic [5:0] q3;
  logic [1:0] tail3;
  logic       hv3, full3, stop3, drop3;
  logic [1:0] head3;
`ifdef QUEUE_DROP_CNT_EN
  logic [7:0] dcnt4, dcnt3;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  elevator_request_queue #(.LVL_W(2), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .pressed_en(pressed_en), .pressed_lvl(pressed_lvl),
    .pos_en(pos_en), .pos_lvl(pos_lvl), .queue(q4), .tail(tail4), .head_valid(hv4),
    .head_lvl(head4), .full(full4), .stop_at_pos_lvl(stop4),
`ifdef QUEUE_DROP_CNT_EN
    .drop_cnt(dcnt4),
`endif
    .drop(drop4));

  elevator_request_queue #(.LVL_W(2), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .pressed_en(pressed_en), .pressed_lvl(pressed_lvl),
    .pos_en(pos_en), .pos_lvl(pos_lvl), .queue(q3), .tail(tail3), .head_valid(hv3),
    .head_lvl(head3), .full(full3), .stop_at_pos_lvl(stop3),
`ifdef QUEUE_DROP_CNT_EN
    .drop_cnt(dcnt3),
`endif
    .drop(drop3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // One clock with the given inputs held across the rising edge; sample 1 time unit later.
  task automatic step(input logic r, input logic pe, input logic [1:0] pl,
                      input logic ve, input logic [1:0] vl);
    rst_n = r; pressed_en = pe; pressed_lvl = pl; pos_en = ve; pos_lvl = vl;
    @(posedge clk);
    #1;
    rst_n = 1'b1; pressed_en = 1'b0; pressed_lvl = 2'd0; pos_en = 1'b0; pos_lvl = 2'd0;
  endtask

  task automatic press(input logic [1:0] l);
    step(1'b1, 1'b1, l, 1'b0, 2'd0);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
  endtask

  task automatic check4(input string tag, input logic [7:0] q, input logic [2:0] t,
                        input logic st, input logic dr);
    check({tag, ".q4"},    q4,    q);
    check({tag, ".tail4"}, tail4, t);
    check({tag, ".hv4"},   hv4,   t != 3'd0);
    check({tag, ".head4"}, head4, q[1:0]);
    check({tag, ".full4"}, full4, t == 3'd4);
    check({tag, ".stop4"}, stop4, st);
    check({tag, ".drop4"}, drop4, dr);
  endtask

  task automatic check3(input string tag, input logic [5:0] q, input logic [1:0] t,
                        input logic st, input logic dr);
    check({tag, ".q3"},    q3,    q);
    check({tag, ".tail3"}, tail3, t);
    check({tag, ".hv3"},   hv3,   t != 2'd0);
    check({tag, ".head3"}, head3, q[1:0]);
    check({tag, ".full3"}, full3, t == 2'd3);
    check({tag, ".stop3"}, stop3, st);
    check({tag, ".drop3"}, drop3, dr);
  endtask

  initial begin
    rst_n = 1'b0; pressed_en = 1'b0; pressed_lvl = 2'd0; pos_en = 1'b0; pos_lvl = 2'd0;

    // Reset then idle
    do_reset();
    check4("rst", 8'h00, 3'd0, 1'b0, 1'b0);
    check3("rst", 6'h00, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      idle();
      check4("idle", 8'h00, 3'd0, 1'b0, 1'b0);
    end
`ifdef QUEUE_DROP_CNT_EN
    check("dcnt_rst", dcnt3, 8'd0);
`endif

    // Ordered fill with a duplicate; DEPTH=3 overflows on the last press
    press(2'd2); check4("fill2", 8'h02, 3'd1, 1'b0, 1'b0);
    press(2'd0); check4("fill0", 8'h02, 3'd2, 1'b0, 1'b0);
    press(2'd2); check4("dup2",  8'h02, 3'd2, 1'b0, 1'b0);
    press(2'd3); check4("fill3", 8'h32, 3'd3, 1'b0, 1'b0);
    check3("fill3", 6'h32, 2'd3, 1'b0, 1'b0);
    press(2'd1); check4("fill1", 8'h72, 3'd4, 1'b0, 1'b0);
    check3("ovf", 6'h32, 2'd3, 1'b0, 1'b1);
`ifdef QUEUE_DROP_CNT_EN
    check("dcnt1", dcnt3, 8'd1);
    check("dcnt4_0", dcnt4, 8'd0);
`endif
    idle();
    check3("ovf_pulse", 6'h32, 2'd3, 1'b0, 1'b0);

    // Press duplicate into a full queue: no drop on DEPTH=4, drop again on DEPTH=3
    press(2'd1);
    check4("full_dup", 8'h72, 3'd4, 1'b0, 1'b0);
    check3("ovf2", 6'h32, 2'd3, 1'b0, 1'b1);
`ifdef QUEUE_DROP_CNT_EN
    check("dcnt2", dcnt3, 8'd2);
`endif

    // pos_en=0 never removes
    step(1'b1, 1'b0, 2'd0, 1'b0, 2'd3);
    check4("noposen", 8'h72, 3'd4, 1'b0, 1'b0);

    // Mid-queue removal of level 0
    step(1'b1, 1'b0, 2'd0, 1'b1, 2'd0);
    check4("rm0", 8'h1E, 3'd3, 1'b1, 1'b0);
    check3("rm0", 6'h0E, 2'd2, 1'b1, 1'b0);
    idle();
    check4("rm0_pulse", 8'h1E, 3'd3, 1'b0, 1'b0);

    // Remove 3 and press 3 in the same cycle on a full queue
    do_reset();
    press(2'd2); press(2'd0); press(2'd3); press(2'd1);
    check4("refill", 8'h72, 3'd4, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'd3, 1'b1, 2'd3);
    check4("sim_rm3", 8'h12, 3'd3, 1'b1, 1'b0);
    check3("sim_rm3", 6'h02, 2'd2, 1'b1, 1'b0);

    // Full DEPTH=3 queue: remove 2 and press new level 1 -> accepted at tail
    do_reset();
    press(2'd2); press(2'd0); press(2'd3);
    check3("fill3b", 6'h32, 2'd3, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'd1, 1'b1, 2'd2);
    check3("sim_add", 6'h1C, 2'd3, 1'b1, 1'b0);
    check4("sim_add", 8'h1C, 3'd3, 1'b1, 1'b0);

    // Empty queue: removal is a no-op; press at current floor is served immediately
    do_reset();
    step(1'b1, 1'b0, 2'd0, 1'b1, 2'd0);
    check4("rm_empty", 8'h00, 3'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'd1, 1'b1, 2'd1);
    check4("serve_now", 8'h00, 3'd0, 1'b1, 1'b0);

    // Reset mid-operation with a press and pos_en in the same cycle
    press(2'd2); press(2'd0); press(2'd3);
    check4("prerst", 8'h32, 3'd3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd1, 1'b1, 2'd0);
    check4("midrst", 8'h00, 3'd0, 1'b0, 1'b0);
    check3("midrst", 6'h00, 2'd0, 1'b0, 1'b0);
`ifdef QUEUE_DROP_CNT_EN
    check("dcnt_midrst", dcnt3, 8'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
